// File: rtl/exc_pkg.sv
// Shared definitions for the exception sequencer: FSM encoding, CP0 register
// numbers, exception codes and handler vectors.
package exc_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      FLUSH   = 2'd1,
      REDIR   = 2'd2,
      ERET_RD = 2'd3
   } state_t;

   localparam logic [4:0] REG_COUNT  = 5'd9;
   localparam logic [4:0] REG_STATUS = 5'd12;
   localparam logic [4:0] REG_CAUSE  = 5'd13;
   localparam logic [4:0] REG_EPC    = 5'd14;

   localparam logic [4:0]  CODE_UDF_DEF = 5'd10;
   localparam logic [4:0]  CODE_OVF_DEF = 5'd12;
   localparam logic [31:0] VEC_UDF_DEF  = 32'h8000_0000;
   localparam logic [31:0] VEC_OVF_DEF  = 32'h8000_0018;

   // Cause register image: ExcCode lives in bits [6:2], everything else reads 0.
   function automatic logic [31:0] cause_word(input logic [4:0] code);
      return {25'd0, code, 2'b00};
   endfunction

endpackage

// File: rtl/cp0_regs.sv
// CP0 register storage (Status.EXL, Cause.ExcCode, EPC, exception count),
// masked mtc0 writes and the combinational read mux.
module cp0_regs
   import exc_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        cap,
   input  logic [31:0] cap_epc,
   input  logic [4:0]  cap_code,
   input  logic        exl_clr,
   input  logic        we,
   input  logic [4:0]  waddr,
   input  logic [31:0] wdata,
   input  logic [4:0]  raddr,
   output logic [31:0] rdata,
   output logic        exl,
   output logic [31:0] epc
);

   logic [4:0]  code;
   logic [31:0] count;

   // Hardware capture and ERET clear take precedence over a same-edge mtc0.
   always_ff @(posedge clk) begin
      if (rst) begin
         exl   <= 1'b0;
         code  <= 5'd0;
         epc   <= 32'd0;
         count <= 32'd0;
      end else if (cap) begin
         exl   <= 1'b1;
         code  <= cap_code;
         epc   <= cap_epc;
         count <= count + 32'd1;
      end else if (exl_clr) begin
         exl <= 1'b0;
      end else if (we) begin
         case (waddr)
            REG_STATUS: exl   <= wdata[1];
            REG_CAUSE:  code  <= wdata[6:2];
            REG_EPC:    epc   <= wdata;
            REG_COUNT:  count <= wdata;
            default:    ;
         endcase
      end else begin
         exl <= exl;
      end
   end

   always_comb begin
      rdata = 32'd0;
      case (raddr)
         REG_STATUS: rdata = {30'd0, exl, 1'b0};
         REG_CAUSE:  rdata = cause_word(code);
         REG_EPC:    rdata = epc;
         REG_COUNT:  rdata = count;
         default:    rdata = 32'd0;
      endcase
   end

endmodule

// File: rtl/exc_ctrl.sv
// Exception sequencer: arbitrates overflow vs. undefined instruction, drives
// the flush-then-redirect sequence and ERET return, and hosts CP0.
module exc_ctrl
   import exc_pkg::*;
#(
   parameter logic [31:0] VEC_UDF  = VEC_UDF_DEF,
   parameter logic [31:0] VEC_OVF  = VEC_OVF_DEF,
   parameter logic [4:0]  CODE_UDF = CODE_UDF_DEF,
   parameter logic [4:0]  CODE_OVF = CODE_OVF_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        udfist,
   input  logic [31:0] udfist_pc,
   input  logic        overflow,
   input  logic [31:0] of_pc,
   input  logic        eret,
   input  logic        mtc0_we,
   input  logic [4:0]  cp0_waddr,
   input  logic [31:0] cp0_wdata,
   input  logic [4:0]  cp0_raddr,
   output logic [31:0] cp0_rdata,
   output logic        stall,
   output logic [2:0]  flush,
   output logic        redirect,
   output logic [31:0] redirect_pc,
   output logic        exl
);

   state_t      state;
   state_t      state_nxt;
   logic [31:0] vec;
   logic [31:0] epc;
   logic        take;
   logic        eret_go;
   logic        exl_clr;
   logic [31:0] cap_epc;
   logic [4:0]  cap_code;
   logic [31:0] cap_vec;

   assign take    = (state == IDLE) & ~exl & (overflow | udfist);
   assign eret_go = (state == IDLE) & eret & exl & ~take;
   assign exl_clr = (state == ERET_RD);

   // Overflow is the older (EX-stage) instruction, so it wins.
   always_comb begin
      cap_epc  = 32'd0;
      cap_code = 5'd0;
      cap_vec  = 32'd0;
      if (overflow) begin
         cap_epc  = of_pc;
         cap_code = CODE_OVF;
         cap_vec  = VEC_OVF;
      end else begin
         cap_epc  = udfist_pc;
         cap_code = CODE_UDF;
         cap_vec  = VEC_UDF;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         vec   <= 32'd0;
      end else begin
         state <= state_nxt;
         if (take) begin
            vec <= cap_vec;
         end else begin
            vec <= vec;
         end
      end
   end

   always_comb begin
      state_nxt   = state;
      flush       = 3'b000;
      redirect    = 1'b0;
      redirect_pc = 32'd0;
      case (state)
         IDLE: begin
            if (take) begin
               state_nxt = FLUSH;
            end else if (eret_go) begin
               state_nxt = ERET_RD;
            end else begin
               state_nxt = IDLE;
            end
         end
         FLUSH: begin
            flush     = 3'b111;
            state_nxt = REDIR;
         end
         REDIR: begin
            flush       = 3'b001;
            redirect    = 1'b1;
            redirect_pc = vec;
            state_nxt   = IDLE;
         end
         ERET_RD: begin
            flush       = 3'b011;
            redirect    = 1'b1;
            redirect_pc = epc;
            state_nxt   = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   assign stall = take | (state != IDLE);

   cp0_regs u_cp0 (
      .clk      (clk),
      .rst      (rst),
      .cap      (take),
      .cap_epc  (cap_epc),
      .cap_code (cap_code),
      .exl_clr  (exl_clr),
      .we       (mtc0_we),
      .waddr    (cp0_waddr),
      .wdata    (cp0_wdata),
      .raddr    (cp0_raddr),
      .rdata    (cp0_rdata),
      .exl      (exl),
      .epc      (epc)
   );

endmodule
